// File: rtl/count8down_pkg.sv
// -----------------------------------------------------------------------------
// count8down_pkg
//   Shared definitions for the count8down timer: the default counter width and
//   the state encoding. The encodings are fixed so that waveforms and any
//   software that snoops the state match the rest of the counter family.
// -----------------------------------------------------------------------------
package count8down_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/count8down.sv
// -----------------------------------------------------------------------------
// count8down
//   Loadable down-counter/timer. A load captures a start value (and keeps a
//   copy for auto-reload), enabled clocks decrement it, and TC pulses for one
//   cycle when the count reaches zero. One-shot mode halts at zero; reload mode
//   spends one enabled cycle at zero and then restarts from the saved value.
//
// Ports
//   clk     rising-edge clock
//   res     asynchronous active-high reset
//   EN      count enable
//   load    synchronous load strobe, overrides EN
//   reload  0 = one-shot, 1 = auto-reload (sampled when leaving zero)
//   CNT_In  load value
//   CNT     current count (registered)
//   TC      terminal-count pulse (registered, one cycle)
//   BUSY    state is RUN
//   DONE    state is HALT
// -----------------------------------------------------------------------------
module count8down
    import count8down_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic             reload,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    state_t           state_q, state_d;

    // Next-state logic. TC defaults low so it can only ever be a single-cycle
    // pulse; every path that leaves it high re-asserts it explicitly.
    always_comb begin
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        state_d = state_q;

        if (load) begin
            cnt_d = CNT_In;
            rld_d = CNT_In;
            if (CNT_In != '0) begin
                state_d = ST_RUN;
            end else begin
                // A zero load is an immediate terminal count.
                state_d = ST_HALT;
                tc_d    = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (EN) begin
                        if (cnt_q > WIDTH'(1)) begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end else if (cnt_q == WIDTH'(1)) begin
                            cnt_d = '0;
                            tc_d  = 1'b1;
                            if (!reload) begin
                                state_d = ST_HALT;
                            end
                        end else begin
                            // Zero cycle in reload mode: restart, or fall
                            // back to HALT if reload was dropped meanwhile.
                            // Never decrement from zero.
                            if (reload) begin
                                cnt_d = rld_q;
                            end else begin
                                state_d = ST_HALT;
                            end
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    // Unused encoding: recover to IDLE.
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q   <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    // Status flags come straight from the state register.
    assign CNT  = cnt_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_HALT);

endmodule

// File: tb/tb_count8down.sv
// -----------------------------------------------------------------------------
// tb_count8down
//   Directed regression for count8down with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_count8down;

    logic       clk;
    logic       res;
    logic       EN;
    logic       load;
    logic       reload;
    logic [7:0] CNT_In;
    logic [7:0] CNT;
    logic       TC;
    logic       BUSY;
    logic       DONE;

    int n_cmp;
    int n_bad;

    count8down #(.WIDTH(8)) dut (
        .clk    (clk),
        .res    (res),
        .EN     (EN),
        .load   (load),
        .reload (reload),
        .CNT_In (CNT_In),
        .CNT    (CNT),
        .TC     (TC),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] c, input logic t,
                             input logic b, input logic d);
        check({tag, ".CNT"},  {24'd0, CNT}, {24'd0, c});
        check({tag, ".TC"},   {31'd0, TC},   {31'd0, t});
        check({tag, ".BUSY"}, {31'd0, BUSY}, {31'd0, b});
        check({tag, ".DONE"}, {31'd0, DONE}, {31'd0, d});
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ar_cnt [8] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00};
    logic       ar_tc  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] gap_cnt [9] = '{8'h04, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'h01, 8'h00};
    logic       gap_en  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        res    = 1'b1;
        EN     = 1'b1;
        load   = 1'b0;
        reload = 1'b0;
        CNT_In = 8'h00;
        #4;
        res = 1'b0;

        // Reset then idle
        check_all("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // One-shot from 3
        load = 1'b1; CNT_In = 8'h03; reload = 1'b0; EN = 1'b1;
        tick();
        load = 1'b0;
        check_all("os_ld", 8'h03, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_2", 8'h02, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_1", 8'h01, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_0", 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("os_halt", 8'h00, 1'b0, 1'b0, 1'b1);
        end

        // Enable gap from 5
        load = 1'b1; CNT_In = 8'h05;
        tick();
        load = 1'b0;
        check_all("gap_ld", 8'h05, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            EN = gap_en[i];
            tick();
            if (i == 8) check_all("gap_end", 8'h00, 1'b1, 1'b0, 1'b1);
            else        check_all("gap", gap_cnt[i], 1'b0, 1'b1, 1'b0);
        end
        EN = 1'b1;
        tick();
        check_all("gap_post", 8'h00, 1'b0, 1'b0, 1'b1);

        // Auto-reload from 2
        load = 1'b1; CNT_In = 8'h02; reload = 1'b1; EN = 1'b1;
        tick();
        load = 1'b0;
        check_all("ar_ld", 8'h02, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all("ar", ar_cnt[i], ar_tc[i], 1'b1, 1'b0);
        end

        // Load collides with terminal count
        tick(); check_all("col_rl", 8'h02, 1'b0, 1'b1, 1'b0);
        tick(); check_all("col_1", 8'h01, 1'b0, 1'b1, 1'b0);
        load = 1'b1; CNT_In = 8'h11;
        tick();
        check_all("col_ld", 8'h11, 1'b0, 1'b1, 1'b0);

        // Zero load
        CNT_In = 8'h00;
        tick();
        load = 1'b0;
        check_all("zld", 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("zld_post", 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-count
        load = 1'b1; CNT_In = 8'hF0; reload = 1'b0;
        tick();
        load = 1'b0;
        check_all("ar_rst_ld", 8'hF0, 1'b0, 1'b1, 1'b0);
        tick(); check_all("rst_ef", 8'hEF, 1'b0, 1'b1, 1'b0);
        tick(); check_all("rst_ee", 8'hEE, 1'b0, 1'b1, 1'b0);
        tick(); check_all("rst_ed", 8'hED, 1'b0, 1'b1, 1'b0);
        #2;
        res = 1'b1;
        #1;
        check_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        res = 1'b0;
        tick();
        check_all("rst_after", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
